gpca_op_sequencer: RTL and testbench
====================================

// Module: gpca_op_sequencer
// PURPOSE
//  Hardware initiator for the 5-row pipelined gpca array: accepts one arithmetic command
//  (mul / square / sqrt / div) on a valid/ready handshake and formats the operands onto X,P,A,B,C.
//  Holds the array inputs for the array latency, captures F/S and returns them on a result handshake.
//  Sits between the control datapath and the combinational/pipelined gpca instance.
// PARAMETERS
//  ARRAY_LAT  5  cycles array inputs are held before F/S are sampled (0 treated as 1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   sequencer can accept command
//  cmd_op     in   2   00 mul, 01 square, 10 sqrt, 11 div
//  cmd_a      in   5   multiplier / value to square
//  cmd_b      in   5   multiplicand / divisor
//  cmd_d      in   10  radicand / dividend
//  X          out  1   array mode: 0 = mul/square, 1 = sqrt/div
//  P          out  5   array P operand
//  A          out  10  array A operand
//  B          out  7   array B operand
//  C          out  7   array C operand
//  F          in   5   array F result (quotient / root)
//  S          in   11  array S result (product / remainder)
//  res_valid  out  1   result held
//  res_ready  in   1   consumer takes result
//  res_f      out  5   captured F
//  res_s      out  11  captured S
//  res_err    out  1   result is an error (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; X,P,A,B,C=0; res_valid=0; res_f,res_s,res_err=0; counter=0.
//  cmd_ready = (state==IDLE). Command is accepted on the clk edge with cmd_valid & cmd_ready.
//  FSM: IDLE -accept-> LOAD -> WAIT (count ARRAY_LAT-1 .. 0) -> CAPT -> DONE -res_ready-> IDLE.
//  LOAD registers array drive, all registered outputs, fixed for the command's whole life:
//   mul   : X=0 P=cmd_a A=0      B=C={cmd_b,2'b00}
//   square: X=0 P=cmd_a A=0      B=7'b0011111 C=7'b0100000
//   sqrt  : X=1 P=0     A=cmd_d  B=7'b0011111 C=7'b0100000
//   div   : X=1 P=0     A=cmd_d  B=C={cmd_b,2'b00}
//  Array drive held through WAIT and CAPT; returns to 0 on entering IDLE.
//  CAPT samples F,S into res_f,res_s; res_valid=1 from DONE entry.
//  Latency: accept edge = cycle 0 -> res_valid high at cycle ARRAY_LAT+3.
//  DONE: res_* stable while res_valid & !res_ready; handshake edge -> res_valid=0, IDLE.
//  No new command is accepted in DONE (cmd_ready=0); back-to-back issue costs one IDLE cycle.
//  cmd_* ignored outside IDLE; F/S ignored outside CAPT.
//  Reset mid-command: command dropped, no result produced.
// CONFIGURATION
//  GPCA_DIV_ZERO_CHECK_EN defined: div with cmd_b==0 goes IDLE->DONE directly (array drive
//   stays 0), res_f=5'h1F, res_s=0, res_err=1, res_valid at cycle 1.
//  Undefined: res_err tied 0; divide-by-zero runs through the array like any div.
// TESTING
//  mul cmd_a=5 cmd_b=7 -> X=0 P=00101 B=C=0011100 held ARRAY_LAT+1 cycles; res_valid at cycle 8 (LAT=5); res_s=S.
//  square cmd_a=5 -> B=0011111 C=0100000 P=00101; res_s captured =25 with gpca instance.
//  sqrt cmd_d=25 -> X=1 A=0000011001; res_f captured; res_valid held 3 cycles with res_ready=0, values stable.
//  div cmd_d=35 cmd_b=5 with macro: normal path; cmd_b=0 -> res_err=1 res_f=1F at cycle 1; without macro res_err=0.
//  rst asserted during WAIT -> outputs 0 immediately, res_valid never rises; next cmd accepted normally.
//  cmd_valid held high through DONE -> second cmd accepted only in the IDLE cycle after result handshake.

Source files
------------

// File: rtl/gpca_op_sequencer.sv
// gpca_op_sequencer: issues one mul/square/sqrt/div command to the gpca array.
// Formats X,P,A,B,C, holds them for ARRAY_LAT cycles, captures F/S, returns result.
// Optional: define GPCA_DIV_ZERO_CHECK_EN to short-circuit divide-by-zero to an
// error result (res_f=1F, res_s=0, res_err=1) without touching the array.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cmd_valid/ready           command handshake
//   cmd_op,a,b,d              op (00 mul,01 sq,10 sqrt,11 div) and operands
//   X,P,A,B,C                 registered array drive
//   F,S                       array results
//   res_valid/ready           result handshake
//   res_f,res_s,res_err       captured result and error flag
module gpca_op_sequencer #(
    parameter int ARRAY_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_a,
    input  logic [4:0]  cmd_b,
    input  logic [9:0]  cmd_d,
    output logic        X,
    output logic [4:0]  P,
    output logic [9:0]  A,
    output logic [6:0]  B,
    output logic [6:0]  C,
    input  logic [4:0]  F,
    input  logic [10:0] S,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [4:0]  res_f,
    output logic [10:0] res_s,
    output logic        res_err
);

    // A zero latency still needs one WAIT cycle for the array to settle.
    localparam int LAT_EFF = (ARRAY_LAT < 1) ? 1 : ARRAY_LAT;
    localparam int CW = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT_EFF - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SQR  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    // Constant B/C pair that turns the array into a squarer / root extractor.
    localparam logic [6:0] K_B = 7'b0011111;
    localparam logic [6:0] K_C = 7'b0100000;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [4:0]    a_q;
    logic [4:0]    b_q;
    logic [9:0]    d_q;

    logic          x_n;
    logic [4:0]    p_n;
    logic [9:0]    a_n;
    logic [6:0]    b_n;
    logic [6:0]    c_n;

    logic          accept;
    logic          div_zero;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

`ifdef GPCA_DIV_ZERO_CHECK_EN
    assign div_zero = (cmd_op == OP_DIV) && (cmd_b == 5'd0);
`else
    assign div_zero = 1'b0;
`endif

    // Operand formatting from the latched command.
    always_comb begin
        x_n = 1'b0;
        p_n = '0;
        a_n = '0;
        b_n = '0;
        c_n = '0;
        unique case (op_q)
            OP_MUL: begin
                p_n = a_q;
                b_n = {b_q, 2'b00};
                c_n = {b_q, 2'b00};
            end
            OP_SQR: begin
                p_n = a_q;
                b_n = K_B;
                c_n = K_C;
            end
            OP_SQRT: begin
                x_n = 1'b1;
                a_n = d_q;
                b_n = K_B;
                c_n = K_C;
            end
            OP_DIV: begin
                x_n = 1'b1;
                a_n = d_q;
                b_n = {b_q, 2'b00};
                c_n = {b_q, 2'b00};
            end
            default: begin
                x_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            X         <= 1'b0;
            P         <= '0;
            A         <= '0;
            B         <= '0;
            C         <= '0;
            res_valid <= 1'b0;
            res_f     <= '0;
            res_s     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            res_f     <= 5'h1F;
                            res_s     <= '0;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            op_q  <= cmd_op;
                            a_q   <= cmd_a;
                            b_q   <= cmd_b;
                            d_q   <= cmd_d;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    X     <= x_n;
                    P     <= p_n;
                    A     <= a_n;
                    B     <= b_n;
                    C     <= c_n;
                    cnt   <= CNT_INIT;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_CAPT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CAPT: begin
                    res_f     <= F;
                    res_s     <= S;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        X         <= 1'b0;
                        P         <= '0;
                        A         <= '0;
                        B         <= '0;
                        C         <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GPCA_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err <= 1'b0;
        end else if (accept) begin
            res_err <= div_zero;
        end else if (state == S_DONE && res_ready) begin
            res_err <= 1'b0;
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpca_op_sequencer.sv
// tb_gpca_op_sequencer: directed + random commands checked against a
// cycle-count reference model and a per-cycle F/S history scoreboard.
module tb_gpca_op_sequencer;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_a = '0;
    logic [4:0]  cmd_b = '0;
    logic [9:0]  cmd_d = '0;
    logic        X;
    logic [4:0]  P;
    logic [9:0]  A;
    logic [6:0]  B;
    logic [6:0]  C;
    logic [4:0]  F = '0;
    logic [10:0] S = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [4:0]  res_f;
    logic [10:0] res_s;
    logic        res_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [4:0]  hist_f [int];
    logic [10:0] hist_s [int];

    gpca_op_sequencer #(.ARRAY_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d),
        .X(X), .P(P), .A(A), .B(B), .C(C),
        .F(F), .S(S),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_s(res_s), .res_err(res_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Random array results, logged by the edge count they are sampled at.
    always @(negedge clk) begin
        F = 5'($urandom);
        S = 11'($urandom);
        hist_f[cyc] = F;
        hist_s[cyc] = S;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] drv_of(input logic [1:0] op,
            input logic [4:0] a, input logic [4:0] b, input logic [9:0] d);
        logic       x;
        logic [4:0] p;
        logic [9:0] aa;
        logic [6:0] bb;
        logic [6:0] cc;
        x = 0; p = 0; aa = 0;
        bb = 7'(b * 4);
        cc = 7'(b * 4);
        if (op == 2'd1 || op == 2'd2) begin
            bb = 7'd31;
            cc = 7'd32;
        end
        if (op[1]) begin
            x = 1;
            aa = d;
        end else begin
            p = a;
        end
        return {x, p, aa, bb, cc};
    endfunction

    function automatic logic [29:0] drv_now();
        return {X, P, A, B, C};
    endfunction

    task automatic scramble();
        cmd_op = 2'($urandom);
        cmd_a = 5'($urandom);
        cmd_b = 5'($urandom);
        cmd_d = 10'($urandom);
    endtask

    // Entered just after a negedge with the DUT idle; returns the same way.
    task automatic issue(input logic [1:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [9:0] d,
                         input int stall, input bit keep);
        logic [29:0] ed;
        logic [4:0]  ef;
        logic [10:0] es;
        bit          dz;
        int          acc;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d;
        cmd_valid = 1'b1;
        chk("rdy_idle", 32'(cmd_ready), 1);
        acc = cyc;
        ed = drv_of(op, a, b, d);
`ifdef GPCA_DIV_ZERO_CHECK_EN
        dz = (op == 2'd3) && (b == 0);
`else
        dz = 0;
`endif
        @(negedge clk);
        if (keep) scramble();
        else cmd_valid = 1'b0;
        if (dz) begin
            chk("dz_vld", 32'(res_valid), 1);
            ef = 5'h1F;
            es = 0;
            chk("dz_drv", 32'(drv_now()), 0);
        end else begin
            chk("load_drv", 32'(drv_now()), 0);
            chk("load_rdy", 32'(cmd_ready), 0);
            for (int j = 1; j <= LAT + 1; j++) begin
                @(negedge clk);
                if (keep) scramble();
                if (j == 1 || j == LAT + 1)
                    chk("drv", 32'(drv_now()), 32'(ed));
                if (j == LAT + 1) begin
                    chk("vld_early", 32'(res_valid), 0);
                    chk("rdy_busy", 32'(cmd_ready), 0);
                end
            end
            @(negedge clk);
            if (keep) scramble();
            ef = hist_f[acc + LAT + 2];
            es = hist_s[acc + LAT + 2];
            chk("vld", 32'(res_valid), 1);
        end
        chk("res_f", 32'(res_f), 32'(ef));
        chk("res_s", 32'(res_s), 32'(es));
        chk("res_err", 32'(res_err), 32'(dz));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (keep) scramble();
            chk("stall_vld", 32'(res_valid), 1);
            chk("stall_f", 32'(res_f), 32'(ef));
            chk("stall_s", 32'(res_s), 32'(es));
            chk("stall_rdy", 32'(cmd_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_vld", 32'(res_valid), 0);
        chk("hs_rdy", 32'(cmd_ready), 1);
        chk("hs_drv", 32'(drv_now()), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(cmd_ready), 1);
        chk("rst_vld", 32'(res_valid), 0);
        chk("rst_drv", 32'(drv_now()), 0);
        chk("rst_res", 32'({res_f, res_s, res_err}), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'd0, 5'd5, 5'd7, 10'd0, 0, 0);
        issue(2'd1, 5'd5, 5'd0, 10'd0, 1, 0);
        issue(2'd2, 5'd0, 5'd0, 10'd25, 3, 0);
        issue(2'd3, 5'd5, 5'd5, 10'd35, 0, 0);
        issue(2'd3, 5'd0, 5'd0, 10'd35, 2, 0);

        // Reset during WAIT drops the command.
        cmd_op = 2'd0; cmd_a = 5'd9; cmd_b = 5'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_drv", 32'(drv_now()), 0);
        chk("mid_rst_vld", 32'(res_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            chk("post_rst_vld", 32'(res_valid), 0);
        end
        issue(2'd1, 5'd31, 5'd0, 10'd0, 0, 0);

        // cmd_valid held high through DONE: next command waits for IDLE.
        issue(2'd0, 5'd3, 5'd4, 10'd0, 2, 1);
        issue(2'd2, 5'd1, 5'd2, 10'd1023, 1, 0);

        for (int n = 0; n < 30; n++) begin
            issue(2'($urandom), 5'($urandom), 5'($urandom_range(0, 3) == 0 ?
                  0 : $urandom), 10'($urandom), $urandom_range(0, 3),
                  (n != 29) && ($urandom_range(0, 2) == 0));
            if (!cmd_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
